// File: rtl/ringbus_hub_pkg.sv
// ringbus_hub_pkg: shared types and constants for the ringbus hub.
//   wr_state_t   write FSM states (IDLE / ISSUE / WAIT)
//   CH_IDX_W     width of channel index fields (cmd_ch, rx_ch)
//   ERR_*        bit positions inside err_flags
package ringbus_hub_pkg;

  localparam int unsigned CH_IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } wr_state_t;

  localparam int unsigned ERR_BAD_CH = 0;
  localparam int unsigned ERR_RD_OF  = 1;
  localparam int unsigned ERR_WR_TO  = 2;
  localparam int unsigned ERR_RSVD   = 3;

endpackage

// File: rtl/ringbus_hub_rr_arbiter.sv
// rr_arbiter: round-robin arbiter over NUM_CH requesters.
//   clk, srst_n  clock, synchronous active-low reset
//   req          per-requester request
//   advance      grant was consumed; move priority past the winner
//   grant        one-hot grant (combinational)
//   grant_idx    index of the granted requester
//   grant_valid  at least one request present
module rr_arbiter
  import ringbus_hub_pkg::*;
#(
  parameter int unsigned NUM_CH = 2
) (
  input  logic                clk,
  input  logic                srst_n,
  input  logic [NUM_CH-1:0]   req,
  input  logic                advance,
  output logic [NUM_CH-1:0]   grant,
  output logic [CH_IDX_W-1:0] grant_idx,
  output logic                grant_valid
);

  // First requester searched on the next arbitration (last winner + 1).
  logic [CH_IDX_W-1:0] next_ptr;

  // Outer loop walks offsets from next_ptr; inner loop maps offset to channel.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (!grant_valid && req[c] && (((32'(next_ptr) + k) % NUM_CH) == c)) begin
          grant[c]    = 1'b1;
          grant_idx   = CH_IDX_W'(c);
          grant_valid = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      next_ptr <= '0;
    end else if (advance && grant_valid) begin
      next_ptr <= CH_IDX_W'((32'(grant_idx) + 1) % NUM_CH);
    end
  end

endmodule

// File: rtl/ringbus_hub.sv
// ringbus_hub: CPU-side front end for NUM_CH ring_bus endpoints.
//   cmd_*        write command stream (valid/ready, channel, address, data)
//   rx_*         tagged receive stream drained round-robin from all rings
//   irq_mask/irq per-channel enable, aggregate "receive data pending" interrupt
//   err_flags    sticky [0] bad channel, [1] rd overflow, [2] write timeout
//   err_clear    clears err_flags (a same-cycle set still lands)
//   ch_*         per-channel endpoint interface (packed NUM_CH lanes)
// Build option: define RINGBUS_HUB_TIMEOUT_EN to abort writes whose
// ch_done_wr does not arrive within TIMEOUT_CYC cycles.
module ringbus_hub
  import ringbus_hub_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                       clk,
  input  logic                       srst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [CH_IDX_W-1:0]        cmd_ch,
  input  logic [DATA_W-1:0]          cmd_addr,
  input  logic [DATA_W-1:0]          cmd_data,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic [DATA_W-1:0]          rx_data,
  output logic [CH_IDX_W-1:0]        rx_ch,
  input  logic [NUM_CH-1:0]          irq_mask,
  output logic                       irq,
  output logic [3:0]                 err_flags,
  input  logic                       err_clear,
  output logic [NUM_CH*DATA_W-1:0]   ch_wr_data,
  output logic [NUM_CH*DATA_W-1:0]   ch_wr_addr,
  output logic [NUM_CH-1:0]          ch_start_wr,
  input  logic [NUM_CH-1:0]          ch_write_ready,
  input  logic [NUM_CH-1:0]          ch_done_wr,
  input  logic [NUM_CH*DATA_W-1:0]   ch_rd_data,
  input  logic [NUM_CH-1:0]          ch_rd_empty,
  input  logic [NUM_CH-1:0]          ch_rd_of,
  output logic [NUM_CH-1:0]          ch_rd_pop
);

  if (NUM_CH < 1 || NUM_CH > 8 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("ringbus_hub: unsupported NUM_CH or TIMEOUT_CYC");
  end

  // ---------------- write path ----------------
  wr_state_t           state;
  logic                cmd_ready_q;
  logic [NUM_CH-1:0]   cmd_sel, lat_sel, start_wr;
  logic [DATA_W-1:0]   lat_addr, lat_data;
  logic                accept, bad_ch, ready_hit, done_hit, timeout_hit;

  assign accept    = cmd_valid & cmd_ready_q;
  assign bad_ch    = 32'(cmd_ch) >= NUM_CH;
  assign ready_hit = |(ch_write_ready & lat_sel);
  assign done_hit  = |(ch_done_wr & lat_sel);

  always_comb begin
    cmd_sel = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) cmd_sel[c] = (32'(cmd_ch) == c);
  end

`ifdef RINGBUS_HUB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] to_cnt;

  // A done arriving on the last allowed cycle still completes normally.
  assign timeout_hit = (state != ST_IDLE) && !done_hit &&
                       (to_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!srst_n || accept) to_cnt <= '0;
    else if (state != ST_IDLE) to_cnt <= to_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state       <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      start_wr    <= '0;
      lat_sel     <= '0;
      lat_addr    <= '0;
      lat_data    <= '0;
    end else begin
      start_wr <= '0;
      unique case (state)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (accept && !bad_ch) begin
            state       <= ST_ISSUE;
            cmd_ready_q <= 1'b0;
            lat_sel     <= cmd_sel;
            lat_addr    <= cmd_addr;
            lat_data    <= cmd_data;
          end
        end
        ST_ISSUE: begin
          if (timeout_hit) begin
            state       <= ST_IDLE;
            cmd_ready_q <= 1'b1;
          end else if (ready_hit) begin
            start_wr <= lat_sel;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (done_hit || timeout_hit) begin
            state       <= ST_IDLE;
            cmd_ready_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Only the latched channel's lanes carry the command while it is in flight.
  always_comb begin
    ch_wr_data = '0;
    ch_wr_addr = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (state != ST_IDLE && lat_sel[c]) begin
        ch_wr_data[c*DATA_W +: DATA_W] = lat_data;
        ch_wr_addr[c*DATA_W +: DATA_W] = lat_addr;
      end
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign ch_start_wr = start_wr;

  // ---------------- error flags ----------------
  logic [3:0] err_q, err_set;

  always_comb begin
    err_set             = '0;
    err_set[ERR_BAD_CH] = accept & bad_ch;
    err_set[ERR_RD_OF]  = |ch_rd_of;
    err_set[ERR_WR_TO]  = timeout_hit;
  end

  always_ff @(posedge clk) begin
    if (!srst_n)        err_q <= '0;
    else if (err_clear) err_q <= err_set;
    else                err_q <= err_q | err_set;
  end

  assign err_flags = err_q;

  // ---------------- read drain ----------------
  logic [NUM_CH-1:0]   grant;
  logic [CH_IDX_W-1:0] grant_idx;
  logic                grant_valid, load;
  logic [DATA_W-1:0]   head;
  logic                rx_valid_q;
  logic [DATA_W-1:0]   rx_data_q;
  logic [CH_IDX_W-1:0] rx_ch_q;

  // Pop is gated by reset so a word is never consumed into a register
  // that is being cleared on the same edge.
  assign load      = srst_n & (~rx_valid_q | rx_ready);
  assign ch_rd_pop = (load && grant_valid) ? grant : '0;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk         (clk),
    .srst_n      (srst_n),
    .req         (~ch_rd_empty),
    .advance     (load),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    head = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (grant[c]) head = ch_rd_data[c*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_ch_q    <= '0;
    end else if (load) begin
      rx_valid_q <= grant_valid;
      if (grant_valid) begin
        rx_data_q <= head;
        rx_ch_q   <= grant_idx;
      end
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign rx_ch    = rx_ch_q;
  assign irq      = |(~ch_rd_empty & irq_mask);

endmodule

// File: tb/tb_ringbus_hub.sv
// tb_ringbus_hub: self-checking bench for ringbus_hub (NUM_CH=2, TIMEOUT_CYC=16).
// Receive buffers are modelled as per-channel circular arrays; the expected
// rx stream is derived from round-robin rules over those arrays.
module tb_ringbus_hub;
  localparam int NUM_CH = 2;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;

  logic                     clk = 1'b0;
  logic                     srst_n;
  logic                     cmd_valid, cmd_ready;
  logic [2:0]               cmd_ch;
  logic [DATA_W-1:0]        cmd_addr, cmd_data;
  logic                     rx_valid, rx_ready;
  logic [DATA_W-1:0]        rx_data;
  logic [2:0]               rx_ch;
  logic [NUM_CH-1:0]        irq_mask;
  logic                     irq;
  logic [3:0]               err_flags;
  logic                     err_clear;
  logic [NUM_CH*DATA_W-1:0] ch_wr_data, ch_wr_addr, ch_rd_data;
  logic [NUM_CH-1:0]        ch_start_wr, ch_write_ready, ch_done_wr;
  logic [NUM_CH-1:0]        ch_rd_empty, ch_rd_of, ch_rd_pop;

  always #5 clk = ~clk;

  ringbus_hub #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .srst_n(srst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_ch(rx_ch),
    .irq_mask(irq_mask), .irq(irq), .err_flags(err_flags), .err_clear(err_clear),
    .ch_wr_data(ch_wr_data), .ch_wr_addr(ch_wr_addr), .ch_start_wr(ch_start_wr),
    .ch_write_ready(ch_write_ready), .ch_done_wr(ch_done_wr),
    .ch_rd_data(ch_rd_data), .ch_rd_empty(ch_rd_empty), .ch_rd_of(ch_rd_of),
    .ch_rd_pop(ch_rd_pop)
  );

  int nvec = 0, nerr = 0;

  // receive buffer contents
  logic [DATA_W-1:0] mem [NUM_CH][DEPTH];
  int rd_p[NUM_CH], wr_p[NUM_CH], cnt[NUM_CH];
  int start_cnt[NUM_CH];
  int pop_total;

  // expected output register and round-robin start channel
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  int                m_ch, m_next;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic refresh();
    for (int c = 0; c < NUM_CH; c++) begin
      ch_rd_empty[c] = (cnt[c] == 0);
      ch_rd_data[c*DATA_W +: DATA_W] = mem[c][rd_p[c]];
    end
  endtask

  task automatic push(input int c, input logic [DATA_W-1:0] d);
    mem[c][wr_p[c]] = d;
    wr_p[c] = (wr_p[c] + 1) % DEPTH;
    cnt[c]++;
    refresh();
  endtask

  // One clock: check read side at negedge, advance, return at posedge+1.
  task automatic cycle();
    logic [NUM_CH-1:0] exp_pop, pop_s;
    logic n_valid, exp_irq;
    logic [DATA_W-1:0] n_data;
    int n_ch, g;
    @(negedge clk);
    check("rx_valid", 64'(rx_valid), 64'(m_valid));
    if (m_valid) begin
      check("rx_data", 64'(rx_data), 64'(m_data));
      check("rx_ch", 64'(rx_ch), 64'(m_ch));
    end
    exp_irq = 1'b0;
    for (int c = 0; c < NUM_CH; c++) if (cnt[c] != 0 && irq_mask[c]) exp_irq = 1'b1;
    check("irq", 64'(irq), 64'(exp_irq));
    exp_pop = '0; n_valid = m_valid; n_data = m_data; n_ch = m_ch; g = -1;
    if (!srst_n) begin
      n_valid = 1'b0; n_data = '0; n_ch = 0;
    end else if (!m_valid || rx_ready) begin
      for (int k = 0; k < NUM_CH; k++) begin
        int c = (m_next + k) % NUM_CH;
        if (g < 0 && cnt[c] != 0) g = c;
      end
      n_valid = (g >= 0);
      if (g >= 0) begin
        exp_pop[g] = 1'b1;
        n_data = mem[g][rd_p[g]];
        n_ch = g;
      end
    end
    check("ch_rd_pop", 64'(ch_rd_pop), 64'(exp_pop));
    pop_s = ch_rd_pop;
    for (int c = 0; c < NUM_CH; c++) if (ch_start_wr[c]) start_cnt[c]++;
    @(posedge clk);
    m_valid = n_valid; m_data = n_data; m_ch = n_ch;
    if (!srst_n) m_next = 0;
    else if (g >= 0) m_next = (g + 1) % NUM_CH;
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (pop_s[c] && cnt[c] != 0) begin
        rd_p[c] = (rd_p[c] + 1) % DEPTH;
        cnt[c]--;
        pop_total++;
      end
    end
    refresh();
  endtask

  typedef struct {
    logic [2:0]        ch;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                rdy_dly;
    int                done_dly;
    logic [3:0]        exp_err;
  } wr_vec_t;

  task automatic do_write(input wr_vec_t v);
    logic [NUM_CH-1:0] sel;
    sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      start_cnt[c] = 0;
      if (32'(v.ch) == c) sel[c] = 1'b1;
    end
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_ch = v.ch; cmd_addr = v.addr; cmd_data = v.data;
    ch_write_ready = '0;
    cycle();
    cmd_valid = 1'b0;
    if (v.exp_err != 4'b0000) begin
      check("bad_ch_err", 64'(err_flags), 64'(v.exp_err));
      check("bad_ch_ready", 64'(cmd_ready), 64'd1);
      repeat (2) cycle();
      for (int c = 0; c < NUM_CH; c++) check("bad_ch_nostart", 64'(start_cnt[c]), 64'd0);
      err_clear = 1'b1;
      cycle();
      err_clear = 1'b0;
      check("err_clear", 64'(err_flags), 64'd0);
      return;
    end
    check("issue_ready", 64'(cmd_ready), 64'd0);
    repeat (v.rdy_dly) begin
      cycle();
      check("issue_hold_start", 64'(ch_start_wr), 64'd0);
    end
    ch_write_ready = '1;
    cycle();
    ch_write_ready = '0;
    check("start_pulse", 64'(ch_start_wr), 64'(sel));
    for (int d = 0; d < v.done_dly; d++) begin
      ch_done_wr = ~sel;
      cycle();
      check("wait_ready", 64'(cmd_ready), 64'd0);
    end
    check("wr_data_lane", 64'(ch_wr_data[v.ch[0]*DATA_W +: DATA_W]), 64'(v.data));
    check("wr_addr_lane", 64'(ch_wr_addr[v.ch[0]*DATA_W +: DATA_W]), 64'(v.addr));
    ch_done_wr = sel;
    cycle();
    ch_done_wr = '0;
    check("done_ready", 64'(cmd_ready), 64'd1);
    for (int c = 0; c < NUM_CH; c++)
      check("start_count", 64'(start_cnt[c]), (sel[c] ? 64'd1 : 64'd0));
    check("err_after_wr", 64'(err_flags), 64'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_start", 64'(ch_start_wr), 64'd0);
    check("rst_pop", 64'(ch_rd_pop), 64'd0);
    check("rst_rx_valid", 64'(rx_valid), 64'd0);
    check("rst_rx_data", 64'(rx_data), 64'd0);
    check("rst_rx_ch", 64'(rx_ch), 64'd0);
    check("rst_err", 64'(err_flags), 64'd0);
  endtask

  wr_vec_t wt[6];

  initial begin
    wt[0] = '{3'd1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 5, 4'b0000};
    wt[1] = '{3'd0, 32'h0000_0020, 32'h1234_5678, 2, 0, 4'b0000};
    wt[2] = '{3'd5, 32'h0000_0030, 32'h0000_0000, 0, 0, 4'b0001};
    wt[3] = '{3'd1, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 1, 2, 4'b0000};
    wt[4] = '{3'd7, 32'h0000_0040, 32'h5555_0000, 0, 0, 4'b0001};
    wt[5] = '{3'd0, 32'h0000_0000, 32'hFFFF_FFFF, 0, 1, 4'b0000};

    srst_n = 1'b0; cmd_valid = 1'b0; cmd_ch = '0; cmd_addr = '0; cmd_data = '0;
    rx_ready = 1'b0; irq_mask = '1; err_clear = 1'b0;
    ch_write_ready = '0; ch_done_wr = '0; ch_rd_of = '0; ch_rd_data = '0;
    m_valid = 1'b0; m_data = '0; m_ch = 0; m_next = 0; pop_total = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      rd_p[c] = 0; wr_p[c] = 0; cnt[c] = 0; start_cnt[c] = 0;
      for (int i = 0; i < DEPTH; i++) mem[c][i] = '0;
    end
    refresh();

    // reset state
    repeat (2) cycle();
    check_reset_outputs();
    srst_n = 1'b1;
    cycle();
    check("ready_after_rst", 64'(cmd_ready), 64'd1);

    // fair drain: 3 words on each channel, alternating at full rate
    for (int i = 0; i < 3; i++) begin
      push(0, 32'h1000_0000 + i);
      push(1, 32'h1100_0000 + i);
    end
    rx_ready = 1'b1; pop_total = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("drain_valid", 64'(rx_valid), 64'd1);
      check("drain_ch", 64'(rx_ch), 64'(i % 2));
      check("drain_data", 64'(rx_data), 64'((i % 2 == 0 ? 32'h1000_0000 : 32'h1100_0000) + 32'(i / 2)));
    end
    check("drain_pops", 64'(pop_total), 64'd6);
    cycle();
    check("drain_empty", 64'(rx_valid), 64'd0);

    // back-pressure: output held, nothing popped while stalled
    rx_ready = 1'b0; pop_total = 0;
    push(1, 32'hCAFE_0001);
    push(1, 32'hCAFE_0002);
    cycle();
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("stall_data", 64'(rx_data), 64'h0000_0000_CAFE_0001);
      check("stall_pops", 64'(pop_total), 64'd1);
    end
    rx_ready = 1'b1;
    cycle();
    check("release_data", 64'(rx_data), 64'h0000_0000_CAFE_0002);
    check("release_pops", 64'(pop_total), 64'd2);
    repeat (2) cycle();

    // write commands from the table
    foreach (wt[i]) do_write(wt[i]);

    // sticky error behaviour
    ch_rd_of = 2'b10;
    cycle();
    ch_rd_of = '0;
    check("of_set", 64'(err_flags), 64'b0010);
    cycle();
    check("of_sticky", 64'(err_flags), 64'b0010);
    ch_rd_of = 2'b01; err_clear = 1'b1;
    cycle();
    ch_rd_of = '0; err_clear = 1'b0;
    check("of_set_wins", 64'(err_flags), 64'b0010);
    cmd_valid = 1'b1; cmd_ch = 3'd6; err_clear = 1'b1;
    cycle();
    cmd_valid = 1'b0; err_clear = 1'b0;
    check("bad_set_wins", 64'(err_flags), 64'b0001);
    err_clear = 1'b1;
    cycle();
    err_clear = 1'b0;
    check("clear_all", 64'(err_flags), 64'd0);

    // randomized read traffic against the model
    for (int n = 0; n < 400; n++) begin
      rx_ready = ($urandom_range(0, 9) < 7);
      irq_mask = NUM_CH'($urandom);
      for (int c = 0; c < NUM_CH; c++)
        if (cnt[c] < DEPTH - 2 && $urandom_range(0, 9) < 4)
          push(c, {4'hA, 4'(c), 24'(n)});
      cycle();
    end
    rx_ready = 1'b1; irq_mask = '1;
    repeat (DEPTH * NUM_CH + 4) cycle();
    check("random_drained", 64'(rx_valid), 64'd0);

    // reset while a write is waiting for done and a word is held
    rx_ready = 1'b0;
    push(0, 32'h7777_0001);
    cycle();
    cmd_valid = 1'b1; cmd_ch = 3'd1; cmd_addr = 32'h44; cmd_data = 32'h4444_4444;
    ch_write_ready = '1;
    cycle();
    cmd_valid = 1'b0;
    cycle();
    ch_write_ready = '0;
    cycle();
    srst_n = 1'b0;
    cycle();
    check_reset_outputs();
    for (int c = 0; c < NUM_CH; c++) start_cnt[c] = 0;
    srst_n = 1'b1; rx_ready = 1'b1;
    cycle();
    check("rst_release_ready", 64'(cmd_ready), 64'd1);
    repeat (3) cycle();
    check("no_reissue", 64'(start_cnt[1]), 64'd0);
    do_write('{3'd1, 32'h0000_0050, 32'h0BAD_F00D, 1, 3, 4'b0000});

    // write whose done never arrives
    for (int c = 0; c < NUM_CH; c++) start_cnt[c] = 0;
    cmd_valid = 1'b1; cmd_ch = 3'd0; cmd_addr = 32'h60; cmd_data = 32'h6666_6666;
    ch_write_ready = '1;
    cycle();
    cmd_valid = 1'b0;
    repeat (15) cycle();
    check("to_not_yet", 64'(err_flags), 64'd0);
    cycle();
    check("to_start_once", 64'(start_cnt[0]), 64'd1);
`ifdef RINGBUS_HUB_TIMEOUT_EN
    check("to_err", 64'(err_flags), 64'b0100);
    check("to_idle", 64'(cmd_ready), 64'd1);
`else
    check("no_to_err", 64'(err_flags), 64'd0);
    check("no_to_stuck", 64'(cmd_ready), 64'd0);
`endif
    ch_write_ready = '0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
